regfile: RTL and testbench
==========================

Name: regfile

Overview:
- 8-entry x 8-bit general-purpose register file for the processor datapath, with one synchronous write port and two combinational read ports (rs, rt).
- Also holds a 1-bit condition bit (CB) used by compare/branch logic, with its own write enable.
- Sits between decode (addresses) and the ALU/writeback stage.

Parameters:
- DATA_W, 8, width of each register and of the data ports.
- ADDR_W, 3, address width; the number of registers is 2**ADDR_W (8).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- write_i  input  1  register write enable.
- write_addr_i  input  ADDR_W  register write address.
- write_data_i  input  DATA_W  register write data.
- rs_addr_i  input  ADDR_W  read port rs address.
- rt_addr_i  input  ADDR_W  read port rt address.
- write_CB_i  input  1  condition-bit write enable.
- cb_data_i  input  1  condition-bit write data.
- rs_data_o  output  DATA_W  contents of register rs_addr_i.
- rt_data_o  output  DATA_W  contents of register rt_addr_i.
- cb_data_o  output  1  current condition-bit value.

Interface (already decided): one clock, clk_i; reset_i is asynchronous and active-high.

Behaviour:
- Reset: while reset_i=1, all 8 registers and the CB clear to 0 immediately, without waiting for a clock edge.
  - rs_data_o, rt_data_o and cb_data_o read 0 during reset.
  - Writes are ignored while reset is asserted.
  - Deasserting reset mid-operation leaves everything at 0; normal operation resumes from the next rising edge.
- Register write: on a rising clk_i edge with write_i=1 and reset_i=0, reg[write_addr_i] <= write_data_i.
  - Write latency is one edge.
  - With write_i=0, the registers hold their values.
- Register 0 is an ordinary writable register; it is not hardwired to zero.
- Reads: rs_data_o = reg[rs_addr_i] and rt_data_o = reg[rt_addr_i], both purely combinational (zero-cycle latency).
  - Both ports may address the same register; both then return the same value.
- Read during write to the same address: there is no bypass.
  - Before the edge, the read returns the old value.
  - After the edge, it returns the new value, within the same cycle's combinational settle.
- CB write: on a rising edge with write_CB_i=1 and reset_i=0, CB <= cb_data_i.
  - cb_data_o = CB, a registered value with one-edge latency; otherwise CB holds.
  - CB writes are fully independent of write_i, so a register write and a CB write in the same cycle both take effect.
- All addresses are in range (0..7) by construction; there is no out-of-range case.
- X or Z on the enables is not supported; the environment drives reset_i and all enables to known values from time 0.

Test Plan:
- Reset: assert reset_i asynchronously, with no clock edge, after loading values -> all reads return 0x00 and cb_data_o=0 immediately; after release, reads remain 0x00.
- Write/read rt: write_i=1, write_addr_i=0, write_data_i=0x11, one edge; then write_i=0 and rt_addr_i=0 -> rt_data_o=0x11.
- Write/read rs: write_addr_i=1, write_data_i=0x22, one edge; then rs_addr_i=1 -> rs_data_o=0x22, and rt_addr_i=0 still reads 0x11.
- Condition bit: write_CB_i=1, cb_data_i=1, one edge -> cb_data_o=1. Then write_CB_i=0, cb_data_i=0, one edge -> cb_data_o stays 1.
- Simultaneous and hold:
  - write_i=1 (addr 7, 0xA5) and write_CB_i=1 (0) in the same edge -> reg7=0xA5 and cb_data_o=0.
  - write_i=0 with a new write_data_i -> reg7 is unchanged.
- Read-during-write: rs_addr_i=2 while writing 0x3C to addr 2 -> rs_data_o shows the old value before the edge and 0x3C after it. Writing all 8 registers with distinct values -> both ports read each value back correctly.

Source files
------------

// File: rtl/regfile.sv
// regfile: 8 x 8-bit general-purpose register file with a 1-bit condition bit.
//
// Ports:
//   clk_i        - clock; all state updates on the rising edge
//   reset_i      - asynchronous active-high reset; clears all registers and CB
//   write_i      - register write enable
//   write_addr_i - register write address
//   write_data_i - register write data
//   rs_addr_i    - read port rs address (combinational read)
//   rt_addr_i    - read port rt address (combinational read)
//   write_CB_i   - condition-bit write enable (independent of write_i)
//   cb_data_i    - condition-bit write data
//   rs_data_o    - contents of register rs_addr_i
//   rt_data_o    - contents of register rt_addr_i
//   cb_data_o    - current condition-bit value
//
// Register 0 is an ordinary register. Reads have no write bypass: a read of the
// register being written shows the old value until the clock edge.
module regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] write_addr_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [ADDR_W-1:0] rs_addr_i,
  input  logic [ADDR_W-1:0] rt_addr_i,
  input  logic              write_CB_i,
  input  logic              cb_data_i,
  output logic [DATA_W-1:0] rs_data_o,
  output logic [DATA_W-1:0] rt_data_o,
  output logic              cb_data_o
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic              cb_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (write_i) begin
      regs_q[write_addr_i] <= write_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cb_q <= 1'b0;
    end else if (write_CB_i) begin
      cb_q <= cb_data_i;
    end
  end

  // Reset clears the array asynchronously, so reads return 0 during reset
  // without any extra gating here.
  always_comb begin
    rs_data_o = regs_q[rs_addr_i];
    rt_data_o = regs_q[rt_addr_i];
    cb_data_o = cb_q;
  end

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed self-checking bench for regfile.
module tb_regfile;

  logic       clk_i = 1'b0;
  logic       reset_i = 1'b1;
  logic       write_i = 1'b0;
  logic [2:0] write_addr_i = '0;
  logic [7:0] write_data_i = '0;
  logic [2:0] rs_addr_i = '0;
  logic [2:0] rt_addr_i = '0;
  logic       write_CB_i = 1'b0;
  logic       cb_data_i = 1'b0;
  logic [7:0] rs_data_o;
  logic [7:0] rt_data_o;
  logic       cb_data_o;

  int total = 0;
  int bad = 0;

  regfile #(
    .DATA_W(8),
    .ADDR_W(3)
  ) dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .write_i     (write_i),
    .write_addr_i(write_addr_i),
    .write_data_i(write_data_i),
    .rs_addr_i   (rs_addr_i),
    .rt_addr_i   (rt_addr_i),
    .write_CB_i  (write_CB_i),
    .cb_data_i   (cb_data_i),
    .rs_data_o   (rs_data_o),
    .rt_data_o   (rt_data_o),
    .cb_data_o   (cb_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [7:0] vals [8];

    // Reset asserted from time 0.
    #2;
    chk("rst_rs", rs_data_o, 8'h00);
    chk("rst_rt", rt_data_o, 8'h00);
    chk("rst_cb", {7'b0, cb_data_o}, 8'h00);
    tick();
    reset_i = 1'b0;

    // Write 0x11 to reg0, read via rt.
    write_i = 1'b1; write_addr_i = 3'd0; write_data_i = 8'h11;
    tick();
    write_i = 1'b0; rt_addr_i = 3'd0;
    #1 chk("wr0_rt", rt_data_o, 8'h11);

    // Write 0x22 to reg1, read via rs; reg0 unchanged.
    write_i = 1'b1; write_addr_i = 3'd1; write_data_i = 8'h22;
    tick();
    write_i = 1'b0; rs_addr_i = 3'd1;
    #1 chk("wr1_rs", rs_data_o, 8'h22);
    chk("wr1_rt0", rt_data_o, 8'h11);

    // Condition bit set, then hold with enable low.
    write_CB_i = 1'b1; cb_data_i = 1'b1;
    tick();
    chk("cb_set", {7'b0, cb_data_o}, 8'h01);
    write_CB_i = 1'b0; cb_data_i = 1'b0;
    tick();
    chk("cb_hold", {7'b0, cb_data_o}, 8'h01);

    // Simultaneous register and CB write.
    write_i = 1'b1; write_addr_i = 3'd7; write_data_i = 8'hA5;
    write_CB_i = 1'b1; cb_data_i = 1'b0;
    rs_addr_i = 3'd7;
    tick();
    write_i = 1'b0; write_CB_i = 1'b0;
    chk("sim_r7", rs_data_o, 8'hA5);
    chk("sim_cb", {7'b0, cb_data_o}, 8'h00);
    write_data_i = 8'hFF;
    tick();
    chk("hold_r7", rs_data_o, 8'hA5);

    // Read during write to reg2: old value before the edge, new after.
    rs_addr_i = 3'd2;
    write_i = 1'b1; write_addr_i = 3'd2; write_data_i = 8'h3C;
    #1 chk("rdw_old", rs_data_o, 8'h00);
    tick();
    write_i = 1'b0;
    chk("rdw_new", rs_data_o, 8'h3C);

    // Write all registers with distinct values, read back on both ports.
    vals = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'h65, 8'hE6, 8'h17, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      write_i = 1'b1; write_addr_i = 3'(i); write_data_i = vals[i];
      tick();
    end
    write_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rs_addr_i = 3'(i);
      rt_addr_i = 3'(7 - i);
      #1;
      chk($sformatf("all_rs%0d", i), rs_data_o, vals[i]);
      chk($sformatf("all_rt%0d", 7 - i), rt_data_o, vals[7 - i]);
    end
    chk("same_addr", {rs_data_o == rt_data_o ? 8'h01 : 8'h00}, (i_eq(rs_addr_i, rt_addr_i)));

    // Set CB, then assert reset asynchronously between edges.
    write_CB_i = 1'b1; cb_data_i = 1'b1;
    tick();
    write_CB_i = 1'b0;
    chk("cb_pre_rst", {7'b0, cb_data_o}, 8'h01);
    rs_addr_i = 3'd5; rt_addr_i = 3'd0;
    #2 reset_i = 1'b1;
    #1;
    chk("arst_rs", rs_data_o, 8'h00);
    chk("arst_rt", rt_data_o, 8'h00);
    chk("arst_cb", {7'b0, cb_data_o}, 8'h00);

    // Writes ignored while in reset.
    write_i = 1'b1; write_addr_i = 3'd3; write_data_i = 8'h77;
    write_CB_i = 1'b1; cb_data_i = 1'b1;
    rs_addr_i = 3'd3;
    tick();
    chk("rst_wr_ign", rs_data_o, 8'h00);
    chk("rst_cb_ign", {7'b0, cb_data_o}, 8'h00);
    write_i = 1'b0; write_CB_i = 1'b0;

    // Release between edges; contents stay zero.
    #2 reset_i = 1'b0;
    tick();
    chk("post_rst_rs", rs_data_o, 8'h00);
    chk("post_rst_cb", {7'b0, cb_data_o}, 8'h00);
    rs_addr_i = 3'd7;
    #1 chk("post_rst_r7", rs_data_o, 8'h00);

    // Normal operation resumes.
    write_i = 1'b1; write_addr_i = 3'd4; write_data_i = 8'h99;
    rt_addr_i = 3'd4;
    tick();
    write_i = 1'b0;
    chk("resume_r4", rt_data_o, 8'h99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  function automatic logic [7:0] i_eq(input logic [2:0] a, input logic [2:0] b);
    return (a == b) ? 8'h01 : 8'h00;
  endfunction

endmodule
